// File: rtl/jt1943_scrrom_fetch.sv
// Scroll ROM fetcher: arbitrates map and tile-gfx word reads onto one SDRAM slot,
// tracking per-client freshness so stale or superseded data is never presented.
module jt1943_scrrom_fetch #(
  parameter logic [17:0] MAP_OFFSET = 18'h00000,
  parameter logic [17:0] SCR_OFFSET = 18'h08000,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] map_addr,
  input  logic [16:0] scr_addr,
  output logic [15:0] map_data,
  output logic [15:0] scrom_data,
  output logic        map_ok,
  output logic        scr_ok,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [15:0] rom_data,
  output logic [3:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ_MAP, REQ_SCR} state_t;

  state_t      state_q, state_d;
  logic [13:0] map_last_q, map_last_d;
  logic [16:0] scr_last_q, scr_last_d;
  logic        map_pend_q, map_pend_d;
  logic        scr_pend_q, scr_pend_d;
  logic [15:0] map_data_q, map_data_d;
  logic [15:0] scr_data_q, scr_data_d;
  logic [16:0] cap_q, cap_d;
  logic [17:0] rom_addr_q, rom_addr_d;
  logic        rom_cs_q, rom_cs_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  err_q, err_d;
  logic        last_scr_q, last_scr_d;

  logic        map_chg, scr_chg, map_need, scr_need, done;
  logic [7:0]  wait_inc;

  // A client counts as pending the moment its address moves, before the flag registers.
  assign map_chg  = (map_addr != map_last_q);
  assign scr_chg  = (scr_addr != scr_last_q);
  assign map_need = map_pend_q | map_chg;
  assign scr_need = scr_pend_q | scr_chg;
  assign wait_inc = wait_q + 8'd1;
  assign done     = rom_ok && (wait_q != 8'd0);

  assign map_ok     = ~map_need;
  assign scr_ok     = ~scr_need;
  assign map_data   = map_data_q;
  assign scrom_data = scr_data_q;
  assign rom_addr   = rom_addr_q;
  assign rom_cs     = rom_cs_q;
  assign err_cnt    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      map_last_q <= '0;
      scr_last_q <= '0;
      map_pend_q <= 1'b1;
      scr_pend_q <= 1'b1;
      map_data_q <= '0;
      scr_data_q <= '0;
      cap_q      <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      wait_q     <= '0;
      err_q      <= '0;
      last_scr_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      map_last_q <= map_last_d;
      scr_last_q <= scr_last_d;
      map_pend_q <= map_pend_d;
      scr_pend_q <= scr_pend_d;
      map_data_q <= map_data_d;
      scr_data_q <= scr_data_d;
      cap_q      <= cap_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      last_scr_q <= last_scr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    map_last_d = map_last_q;
    scr_last_d = scr_last_q;
    map_pend_d = map_pend_q;
    scr_pend_d = scr_pend_q;
    map_data_d = map_data_q;
    scr_data_d = scr_data_q;
    cap_d      = cap_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    wait_d     = wait_q;
    err_d      = err_q;
    last_scr_d = last_scr_q;

    if (map_chg) begin
      map_last_d = map_addr;
      map_pend_d = 1'b1;
    end
    if (scr_chg) begin
      scr_last_d = scr_addr;
      scr_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        rom_cs_d = 1'b0;
        if (map_need && (!scr_need || last_scr_q)) begin
          state_d    = REQ_MAP;
          cap_d      = {3'b000, map_addr};
          rom_addr_d = MAP_OFFSET + {4'b0000, map_addr};
          rom_cs_d   = 1'b1;
          wait_d     = '0;
          last_scr_d = 1'b0;
        end else if (scr_need) begin
          state_d    = REQ_SCR;
          cap_d      = scr_addr;
          rom_addr_d = SCR_OFFSET + {1'b0, scr_addr};
          rom_cs_d   = 1'b1;
          wait_d     = '0;
          last_scr_d = 1'b1;
        end
      end
      REQ_MAP, REQ_SCR: begin
        wait_d = wait_inc;
        if (done) begin
          state_d  = IDLE;
          rom_cs_d = 1'b0;
          // A same-cycle address move supersedes the returning word.
          if (state_q == REQ_MAP) begin
            if ((cap_q == {3'b000, map_last_q}) && !map_chg) begin
              map_data_d = rom_data;
              map_pend_d = 1'b0;
            end
          end else begin
            if ((cap_q == scr_last_q) && !scr_chg) begin
              scr_data_d = rom_data;
              scr_pend_d = 1'b0;
            end
          end
        end else if (wait_inc == TIMEOUT) begin
          state_d  = IDLE;
          rom_cs_d = 1'b0;
          if (err_q != 4'hF) err_d = err_q + 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        rom_cs_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jt1943_scrrom_fetch.sv
// Directed self-checking bench for jt1943_scrrom_fetch (TIMEOUT overridden to 8).
module tb_jt1943_scrrom_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] map_addr;
  logic [16:0] scr_addr;
  logic [15:0] map_data;
  logic [15:0] scrom_data;
  logic        map_ok;
  logic        scr_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [15:0] rom_data;
  logic [3:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jt1943_scrrom_fetch #(
    .MAP_OFFSET(18'h00000),
    .SCR_OFFSET(18'h08000),
    .TIMEOUT   (8'd8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .map_addr  (map_addr),
    .scr_addr  (scr_addr),
    .map_data  (map_data),
    .scrom_data(scrom_data),
    .map_ok    (map_ok),
    .scr_ok    (scr_ok),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_ok    (rom_ok),
    .rom_data  (rom_data),
    .err_cnt   (err_cnt)
  );

  // ROM contents seen by the fetcher: a fixed scramble of the word address.
  function automatic logic [15:0] model(input logic [17:0] a);
    return a[15:0] ^ {14'd0, a[17:16]} ^ 16'hC3A5;
  endfunction

  task automatic serve(input logic [17:0] exp_addr, input bit early, input string tag);
    int t;
    t = 0;
    while (rom_cs !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rom_cs !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_start rom_cs=%b expected 1", tag, rom_cs);
      return;
    end
    n_checks++;
    if (rom_addr !== exp_addr) begin
      n_fail++;
      $display("[TB] FAIL %s_addr rom_addr=%h expected %h", tag, rom_addr, exp_addr);
    end
    if (early) begin
      rom_ok   = 1'b1;
      rom_data = 16'hBAD0;
    end
    @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b1 || rom_addr !== exp_addr) begin
      n_fail++;
      $display("[TB] FAIL %s_hold rom_cs=%b rom_addr=%h expected 1 %h", tag, rom_cs, rom_addr, exp_addr);
    end
    rom_ok   = 1'b1;
    rom_data = model(exp_addr);
    @(negedge clk);
    rom_ok   = 1'b0;
    rom_data = 16'hDEAD;
    n_checks++;
    if (rom_cs !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_release rom_cs=%b expected 0", tag, rom_cs);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    map_addr = '0;
    scr_addr = '0;
    rom_ok   = 1'b0;
    rom_data = 16'hDEAD;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rom_cs, map_ok, scr_ok} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags cs/map_ok/scr_ok=%b expected 000", {rom_cs, map_ok, scr_ok});
    end
    n_checks++;
    if (rom_addr !== 18'h0 || map_data !== 16'h0 || scrom_data !== 16'h0 || err_cnt !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_values addr=%h map=%h scr=%h err=%h expected all 0",
               rom_addr, map_data, scrom_data, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_initial_fetch();
    serve(18'h00000, 1'b0, "map0");
    n_checks++;
    if (map_ok !== 1'b1 || scr_ok !== 1'b0 || map_data !== model(18'h00000)) begin
      n_fail++;
      $display("[TB] FAIL init_map map_ok=%b scr_ok=%b map_data=%h expected 1 0 %h",
               map_ok, scr_ok, map_data, model(18'h00000));
    end
    serve(18'h08000, 1'b0, "scr0");
    n_checks++;
    if (map_ok !== 1'b1 || scr_ok !== 1'b1 || scrom_data !== model(18'h08000)) begin
      n_fail++;
      $display("[TB] FAIL init_scr map_ok=%b scr_ok=%b scrom_data=%h expected 1 1 %h",
               map_ok, scr_ok, scrom_data, model(18'h08000));
    end
  endtask

  task automatic test_scr_latency();
    @(negedge clk);
    scr_addr = 17'h1ABCD;
    #1;
    n_checks++;
    if (scr_ok !== 1'b0 || map_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL lat_ok_drop scr_ok=%b map_ok=%b expected 0 1", scr_ok, map_ok);
    end
    @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 18'h22BCD || scrom_data !== model(18'h08000)) begin
      n_fail++;
      $display("[TB] FAIL lat_req cs=%b addr=%h data=%h expected 1 22bcd %h",
               rom_cs, rom_addr, scrom_data, model(18'h08000));
    end
    @(negedge clk);
    rom_ok   = 1'b1;
    rom_data = model(18'h22BCD);
    n_checks++;
    if (scrom_data !== model(18'h08000) || scr_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lat_early data=%h scr_ok=%b expected %h 0", scrom_data, scr_ok, model(18'h08000));
    end
    @(negedge clk);
    rom_ok   = 1'b0;
    rom_data = 16'hDEAD;
    n_checks++;
    if (scrom_data !== model(18'h22BCD) || scr_ok !== 1'b1 || rom_cs !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lat_done data=%h scr_ok=%b cs=%b expected %h 1 0",
               scrom_data, scr_ok, rom_cs, model(18'h22BCD));
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    map_addr = 14'h0005;
    scr_addr = 17'h00077;
    serve(18'h00005, 1'b0, "rr_map");
    n_checks++;
    if (map_data !== model(18'h00005) || map_ok !== 1'b1 || scr_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rr_map_data data=%h map_ok=%b scr_ok=%b expected %h 1 0",
               map_data, map_ok, scr_ok, model(18'h00005));
    end
    serve(18'h08077, 1'b1, "rr_scr");
    n_checks++;
    if (scrom_data !== model(18'h08077) || scr_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rr_scr_data data=%h scr_ok=%b expected %h 1", scrom_data, scr_ok, model(18'h08077));
    end
  endtask

  task automatic test_inflight_change();
    @(negedge clk);
    map_addr = 14'h0010;
    @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 18'h00010) begin
      n_fail++;
      $display("[TB] FAIL infl_req cs=%b addr=%h expected 1 00010", rom_cs, rom_addr);
    end
    map_addr = 14'h0020;
    @(negedge clk);
    rom_ok   = 1'b1;
    rom_data = model(18'h00010);
    @(negedge clk);
    rom_ok   = 1'b0;
    rom_data = 16'hDEAD;
    n_checks++;
    if (map_data !== model(18'h00005) || map_ok !== 1'b0 || rom_cs !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL infl_discard data=%h map_ok=%b cs=%b expected %h 0 0",
               map_data, map_ok, rom_cs, model(18'h00005));
    end
    serve(18'h00020, 1'b0, "infl_refetch");
    n_checks++;
    if (map_data !== model(18'h00020) || map_ok !== 1'b1 || scr_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL infl_latch data=%h map_ok=%b scr_ok=%b expected %h 1 1",
               map_data, map_ok, scr_ok, model(18'h00020));
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    map_addr = 14'h0030;
    @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 18'h00030) begin
      n_fail++;
      $display("[TB] FAIL same_req cs=%b addr=%h expected 1 00030", rom_cs, rom_addr);
    end
    @(negedge clk);
    rom_ok   = 1'b1;
    rom_data = model(18'h00030);
    map_addr = 14'h0031;
    @(negedge clk);
    rom_ok   = 1'b0;
    rom_data = 16'hDEAD;
    n_checks++;
    if (map_data !== model(18'h00020) || map_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL same_discard data=%h map_ok=%b expected %h 0", map_data, map_ok, model(18'h00020));
    end
    serve(18'h00031, 1'b0, "same_refetch");
    n_checks++;
    if (map_data !== model(18'h00031) || map_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL same_latch data=%h map_ok=%b expected %h 1", map_data, map_ok, model(18'h00031));
    end
  endtask

  task automatic test_timeout();
    int t;
    int cnt;
    @(negedge clk);
    scr_addr = 17'h00042;
    for (int k = 1; k <= 16; k++) begin
      t = 0;
      while (rom_cs !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      cnt = 0;
      while (rom_cs === 1'b1 && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      n_checks++;
      if (cnt != 8) begin
        n_fail++;
        $display("[TB] FAIL to_len abort %0d rom_cs cycles=%0d expected 8", k, cnt);
      end
      n_checks++;
      if (err_cnt !== ((k > 15) ? 4'd15 : 4'(k)) || scr_ok !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL to_err abort %0d err_cnt=%0d scr_ok=%b expected %0d 0",
                 k, err_cnt, scr_ok, (k > 15) ? 15 : k);
      end
    end
    serve(18'h08042, 1'b0, "to_retry");
    n_checks++;
    if (scrom_data !== model(18'h08042) || scr_ok !== 1'b1 || err_cnt !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL to_recover data=%h scr_ok=%b err=%0d expected %h 1 15",
               scrom_data, scr_ok, err_cnt, model(18'h08042));
    end
  endtask

  task automatic test_reset_midrequest();
    @(negedge clk);
    map_addr = 14'h0100;
    @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 18'h00100) begin
      n_fail++;
      $display("[TB] FAIL rst_req cs=%b addr=%h expected 1 00100", rom_cs, rom_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rom_cs !== 1'b0 || rom_addr !== 18'h0 || map_data !== 16'h0 || scrom_data !== 16'h0 ||
        err_cnt !== 4'h0 || map_ok !== 1'b0 || scr_ok !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_async cs=%b addr=%h map=%h scr=%h err=%h ok=%b%b expected all 0",
               rom_cs, rom_addr, map_data, scrom_data, err_cnt, map_ok, scr_ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serve(18'h00100, 1'b0, "rst_map");
    n_checks++;
    if (map_data !== model(18'h00100) || map_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_map_data data=%h map_ok=%b expected %h 1", map_data, map_ok, model(18'h00100));
    end
    serve(18'h08042, 1'b0, "rst_scr");
    n_checks++;
    if (scrom_data !== model(18'h08042) || scr_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_scr_data data=%h scr_ok=%b expected %h 1", scrom_data, scr_ok, model(18'h08042));
    end
  endtask

  initial begin
    test_reset();
    test_initial_fetch();
    test_scr_latency();
    test_round_robin();
    test_inflight_change();
    test_same_cycle();
    test_timeout();
    test_reset_midrequest();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/jt1943_scrrom_fetch.md
JT1943_SCRROM_FETCH -- requirements
Module: jt1943_scrrom_fetch

Interface
REQ-001 SHALL have parameter MAP_OFFSET, default 18'h00000: word offset of the scroll map region in the ROM port space.
REQ-002 SHALL have parameter SCR_OFFSET, default 18'h08000: word offset of the scroll tile graphics region.
REQ-003 SHALL have parameter TIMEOUT, default 8'd255: maximum request cycles before abort.
REQ-004 Ports, one clock; reset is asynchronous and active-low:
  clk         in   1   system clock, >12 MHz
  rst_n       in   1   asynchronous active-low reset
  map_addr    in   14  map word address from the scroll stage
  scr_addr    in   17  tile gfx word address from the scroll stage
  map_data    out  16  latched map word
  scrom_data  out  16  latched gfx word
  map_ok      out  1   map_data matches current map_addr
  scr_ok      out  1   scrom_data matches current scr_addr
  rom_addr    out  18  word address to SDRAM slot
  rom_cs      out  1   request strobe
  rom_ok      in   1   SDRAM data valid
  rom_data    in   16  SDRAM read data
  err_cnt     out  4   saturating timeout count

Function
REQ-005 Each client (map, scr) SHALL keep a last-address register and a pending flag; on any clk edge where the input address differs from the last-address register, it SHALL load the new address, set pending, and clear its ok output in the same cycle.
REQ-006 map_ok SHALL equal not pending for map, and scr_ok SHALL equal not pending for scr.
REQ-007 The FSM SHALL have states IDLE, REQ_MAP and REQ_SCR.
REQ-008 From IDLE, the FSM SHALL choose a pending client as follows.
  - Only one pending: that client.
  - Both pending: the client not served last (round-robin).
  - After reset, scr is treated as served last, so map goes first.
REQ-009 On entering REQ_x, the FSM SHALL drive rom_cs=1.
  - rom_addr = x_OFFSET + zero-extended captured address, 18-bit modulo wrap.
  - The captured address and rom_addr SHALL stay constant for the whole request.
REQ-010 In the first cycle of a request, rom_ok SHALL be ignored.
REQ-011 From the second cycle on, rom_ok=1 SHALL complete the request.
  - If the captured address still equals the client's last-address register, the block SHALL latch rom_data into the client's data output and clear pending.
  - Otherwise it SHALL discard the data and leave pending set.
  - In both cases the FSM SHALL return to IDLE with rom_cs=0 for at least one cycle.
REQ-012 A 8-bit wait counter SHALL clear on entering REQ_x and increment each cycle in REQ_x.
  - When it reaches TIMEOUT without completion, the FSM SHALL abort: rom_cs=0, go to IDLE, keep pending set.
  - err_cnt SHALL increment, saturating at 15.
REQ-013 Data outputs SHALL change only on a successful completion; if the address changes while the data is stale, the old value SHALL remain.
REQ-014 If an address change and a completion for the same client happen in the same cycle, the change SHALL win: data is discarded and pending stays set.
REQ-015 Latency with rom_ok asserted on the second request cycle SHALL be 3 clk from the address change to ok=1 (detect, request, complete).

Reset
REQ-016 While rst_n=0, and immediately on assertion, the block SHALL set:
  - state=IDLE, rom_cs=0, rom_addr=0;
  - map_data=0, scrom_data=0, err_cnt=0, wait counter=0;
  - last-address registers=0, both pending flags=1 (so map_ok=0, scr_ok=0).
REQ-017 Reset asserted mid-request SHALL drop rom_cs asynchronously and abandon the request; after release, both clients SHALL be fetched again, map first.

Verification
REQ-018 Release reset with map_addr=0, scr_addr=0 and rom_ok returned on the 2nd request cycle -> map fetch at rom_addr=0x00000 then scr fetch at rom_addr=0x08000; both ok=1; data matches the model.
REQ-019 Change scr_addr to 0x1ABCD while idle -> scr_ok drops in the same cycle; rom_addr=0x08000+0x1ABCD wrapped=0x22BCD; scrom_data updates 3 clk after the change.
REQ-020 Change map_addr and scr_addr in the same cycle after a scr service -> map served first, then scr; rom_cs low for at least one cycle between requests.
REQ-021 Change map_addr from 0x0010 to 0x0020 during an in-flight map request -> first result discarded, map_data unchanged; refetch at 0x0020 latched; map_ok=1 only after that.
REQ-022 Never assert rom_ok, TIMEOUT=8 -> rom_cs falls after 8 request cycles; err_cnt increments per abort and stops at 15; request retried.
REQ-023 Drive rst_n=0 mid-request -> rom_cs=0 immediately, all outputs at reset values; after release, the map fetch is reissued.
